// File: rtl/pipelined_control_unit_if.sv
// Bus between the control unit and the datapath/hazard unit.
// Instruction word and flush come in. Stage-tagged control bits and the retired count go out.
// Optional macro ILLEGAL_INSTR_EN adds the Illegal_W flag.
interface pipelined_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      Instr_D;
  logic             Flush_E;
  logic [1:0]       ImmSrc_D;
  logic [2:0]       ALUControl_E;
  logic             ALUSrcB_E;
  logic             Branch_E;
  logic             Jump_E;
  logic             ResultSrc_E0;
  logic             RegWrite_M;
  logic             MemWrite_M;
  logic             RegWrite_W;
  logic [1:0]       ResultSrc_W;
  logic [CNT_W-1:0] Retired_W;
`ifdef ILLEGAL_INSTR_EN
  logic             Illegal_W;
`endif

  // Datapath / hazard-unit side
  modport master (
`ifdef ILLEGAL_INSTR_EN
    input  Illegal_W,
`endif
    output Instr_D, Flush_E,
    input  ImmSrc_D, ALUControl_E, ALUSrcB_E, Branch_E, Jump_E, ResultSrc_E0,
    input  RegWrite_M, MemWrite_M, RegWrite_W, ResultSrc_W, Retired_W
  );

  // Control-unit side
  modport slave (
`ifdef ILLEGAL_INSTR_EN
    output Illegal_W,
`endif
    input  Instr_D, Flush_E,
    output ImmSrc_D, ALUControl_E, ALUSrcB_E, Branch_E, Jump_E, ResultSrc_E0,
    output RegWrite_M, MemWrite_M, RegWrite_W, ResultSrc_W, Retired_W
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Control path for a 5-stage RV32I pipeline.
// The D-stage instruction is decoded combinationally. Its control bits then ride through private
// D/E, E/M and M/W registers, so each bit appears in the stage that consumes it.
// A wrapping counter tallies valid instructions as they retire from W.
// Optional macro ILLEGAL_INSTR_EN flags unknown non-zero opcodes and pipes the flag to Illegal_W.
module pipelined_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  pipelined_control_unit_if.slave  bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Everything used in E or later
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src_b;
`ifdef ILLEGAL_INSTR_EN
    logic       illegal;
`endif
  } ctrl_e_t;

  // Only what M and W still need
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
`ifdef ILLEGAL_INSTR_EN
    logic       illegal;
`endif
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
`ifdef ILLEGAL_INSTR_EN
    logic       illegal;
`endif
  } ctrl_w_t;

  // R-type and I-ALU share this funct3 map; only R-type may request sub
  function automatic logic [2:0] alu_dec(input logic [2:0] funct3, input logic sub_req);
    logic [2:0] alu;
    alu = 3'b000;
    case (funct3)
      3'b000:  alu = sub_req ? 3'b001 : 3'b000;
      3'b010:  alu = 3'b101;
      3'b110:  alu = 3'b011;
      3'b111:  alu = 3'b010;
      default: alu = 3'b000;
    endcase
    return alu;
  endfunction

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             known_op;
  logic [1:0]       imm_src_p0;
  ctrl_e_t          ctrl_p0;
  logic             vld_p0;

  ctrl_e_t          ctrl_p1_d, ctrl_p1_q;
  ctrl_m_t          ctrl_p2_d, ctrl_p2_q;
  ctrl_w_t          ctrl_p3_d, ctrl_p3_q;
  logic             vld_p1_d, vld_p1_q;
  logic             vld_p2_d, vld_p2_q;
  logic             vld_p3_d, vld_p3_q;
  logic [CNT_W-1:0] retired_d, retired_q;

  assign opcode   = bus.Instr_D[6:0];
  assign funct3   = bus.Instr_D[14:12];
  assign funct7_5 = bus.Instr_D[30];

  // ---- D stage: combinational decode; unknown opcodes become bubbles
  always_comb begin
    ctrl_p0    = '0;
    imm_src_p0 = 2'b00;
    known_op   = 1'b0;
    case (opcode)
      OP_LW: begin
        known_op             = 1'b1;
        ctrl_p0.reg_write    = 1'b1;
        ctrl_p0.alu_src_b    = 1'b1;
        ctrl_p0.result_src   = 2'b01;
      end
      OP_SW: begin
        known_op             = 1'b1;
        ctrl_p0.mem_write    = 1'b1;
        ctrl_p0.alu_src_b    = 1'b1;
        imm_src_p0           = 2'b01;
      end
      OP_R: begin
        known_op             = 1'b1;
        ctrl_p0.reg_write    = 1'b1;
        ctrl_p0.alu_control  = alu_dec(funct3, funct7_5);
      end
      OP_IALU: begin
        known_op             = 1'b1;
        ctrl_p0.reg_write    = 1'b1;
        ctrl_p0.alu_src_b    = 1'b1;
        ctrl_p0.alu_control  = alu_dec(funct3, 1'b0);
      end
      OP_BEQ: begin
        known_op             = 1'b1;
        ctrl_p0.branch       = 1'b1;
        ctrl_p0.alu_control  = 3'b001;
        imm_src_p0           = 2'b10;
      end
      OP_JAL: begin
        known_op             = 1'b1;
        ctrl_p0.jump         = 1'b1;
        ctrl_p0.reg_write    = 1'b1;
        ctrl_p0.result_src   = 2'b10;
        imm_src_p0           = 2'b11;
      end
      default: begin
        known_op             = 1'b0;
      end
    endcase
    vld_p0 = known_op && (bus.Instr_D != 32'd0);
`ifdef ILLEGAL_INSTR_EN
    ctrl_p0.illegal = !known_op && (bus.Instr_D != 32'd0);
`endif
  end

  // Next-state for the three control registers and the retire counter
  always_comb begin
    // ---- D/E: flush turns the slot into a bubble
    ctrl_p1_d = bus.Flush_E ? '0   : ctrl_p0;
    vld_p1_d  = bus.Flush_E ? 1'b0 : vld_p0;
    // ---- E/M
    ctrl_p2_d            = '0;
    ctrl_p2_d.reg_write  = ctrl_p1_q.reg_write;
    ctrl_p2_d.result_src = ctrl_p1_q.result_src;
    ctrl_p2_d.mem_write  = ctrl_p1_q.mem_write;
`ifdef ILLEGAL_INSTR_EN
    ctrl_p2_d.illegal    = ctrl_p1_q.illegal;
`endif
    vld_p2_d = vld_p1_q;
    // ---- M/W
    ctrl_p3_d            = '0;
    ctrl_p3_d.reg_write  = ctrl_p2_q.reg_write;
    ctrl_p3_d.result_src = ctrl_p2_q.result_src;
`ifdef ILLEGAL_INSTR_EN
    ctrl_p3_d.illegal    = ctrl_p2_q.illegal;
`endif
    vld_p3_d = vld_p2_q;
    // ---- retire: the W instruction is counted as it leaves; wraps silently
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, vld_p3_q};
  end

  // State registers; reset clears everything and takes priority over any increment
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_p1_q <= '0;
      ctrl_p2_q <= '0;
      ctrl_p3_q <= '0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      ctrl_p1_q <= ctrl_p1_d;
      ctrl_p2_q <= ctrl_p2_d;
      ctrl_p3_q <= ctrl_p3_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      vld_p3_q  <= vld_p3_d;
      retired_q <= retired_d;
    end
  end

  assign bus.ImmSrc_D     = imm_src_p0;
  assign bus.ALUControl_E = ctrl_p1_q.alu_control;
  assign bus.ALUSrcB_E    = ctrl_p1_q.alu_src_b;
  assign bus.Branch_E     = ctrl_p1_q.branch;
  assign bus.Jump_E       = ctrl_p1_q.jump;
  assign bus.ResultSrc_E0 = ctrl_p1_q.result_src[0];
  assign bus.RegWrite_M   = ctrl_p2_q.reg_write;
  assign bus.MemWrite_M   = ctrl_p2_q.mem_write;
  assign bus.RegWrite_W   = ctrl_p3_q.reg_write;
  assign bus.ResultSrc_W  = ctrl_p3_q.result_src;
  assign bus.Retired_W    = retired_q;
`ifdef ILLEGAL_INSTR_EN
  assign bus.Illegal_W    = ctrl_p3_q.illegal;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed sequence with literal expectations, then a random stream.
// Every cycle is compared against a queue-based model. Two instances run side by side:
// one at the default 32-bit counter width and one at 4 bits, so counter wrap is exercised.
// Checks Illegal_W when ILLEGAL_INSTR_EN is defined.
module tb_pipelined_control_unit;

  typedef struct packed {
    logic [1:0] imm;
    logic [2:0] alu;
    logic       srcb;
    logic       br;
    logic       jmp;
    logic       mw;
    logic       rw;
    logic [1:0] res;
    logic       vld;
    logic       ill;
  } exp_t;

  logic clk;
  logic rst_r;
  int   total;
  int   bad;

  exp_t        pipe[$];      // [0]=E, [1]=M, [2]=W
  int unsigned retired_cnt;

  pipelined_control_unit_if #(.CNT_W(32)) ifc ();
  pipelined_control_unit_if #(.CNT_W(4))  ifc4 ();

  pipelined_control_unit #(.CNT_W(32)) dut (.clk(clk), .reset(rst_r), .bus(ifc));
  pipelined_control_unit #(.CNT_W(4))  dut4 (.clk(clk), .reset(rst_r), .bus(ifc4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: the rules read straight off the instruction table
  function automatic exp_t model_decode(input logic [31:0] i);
    exp_t r;
    logic [2:0] f3;
    r  = '0;
    f3 = i[14:12];
    if (i[6:0] == 7'h03) begin
      r.rw = 1; r.srcb = 1; r.res = 2'd1; r.vld = 1;
    end else if (i[6:0] == 7'h23) begin
      r.mw = 1; r.srcb = 1; r.imm = 2'd1; r.vld = 1;
    end else if (i[6:0] == 7'h33 || i[6:0] == 7'h13) begin
      r.rw = 1; r.vld = 1;
      r.srcb = (i[6:0] == 7'h13);
      if (f3 == 3'd0)      r.alu = (i[6:0] == 7'h33 && i[30]) ? 3'd1 : 3'd0;
      else if (f3 == 3'd2) r.alu = 3'd5;
      else if (f3 == 3'd6) r.alu = 3'd3;
      else if (f3 == 3'd7) r.alu = 3'd2;
    end else if (i[6:0] == 7'h63) begin
      r.br = 1; r.imm = 2'd2; r.alu = 3'd1; r.vld = 1;
    end else if (i[6:0] == 7'h6F) begin
      r.jmp = 1; r.rw = 1; r.imm = 2'd3; r.res = 2'd2; r.vld = 1;
    end else begin
      r.ill = (i != 32'd0);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Model advance at a clock edge
  task automatic model_edge(input logic [31:0] instr, input logic fl, input logic rs);
    exp_t z;
    z = '0;
    if (rs) begin
      pipe = {z, z, z};
      retired_cnt = 0;
    end else begin
      if (pipe[2].vld) retired_cnt++;
      void'(pipe.pop_back());
      pipe.push_front(fl ? z : model_decode(instr));
    end
  endtask

  // Full output comparison against the model
  task automatic check_model();
    exp_t d;
    logic [31:0] r32;
    logic [3:0]  r4;
    d   = model_decode(ifc.Instr_D);
    r32 = retired_cnt;
    r4  = r32[3:0];
    chk("ImmSrc_D",     ifc.ImmSrc_D,     d.imm);
    chk("ALUControl_E", ifc.ALUControl_E, pipe[0].alu);
    chk("ALUSrcB_E",    ifc.ALUSrcB_E,    pipe[0].srcb);
    chk("Branch_E",     ifc.Branch_E,     pipe[0].br);
    chk("Jump_E",       ifc.Jump_E,       pipe[0].jmp);
    chk("ResultSrc_E0", ifc.ResultSrc_E0, pipe[0].res[0]);
    chk("RegWrite_M",   ifc.RegWrite_M,   pipe[1].rw);
    chk("MemWrite_M",   ifc.MemWrite_M,   pipe[1].mw);
    chk("RegWrite_W",   ifc.RegWrite_W,   pipe[2].rw);
    chk("ResultSrc_W",  ifc.ResultSrc_W,  pipe[2].res);
    chk("Retired_W32",  ifc.Retired_W,    r32);
    chk("Retired_W4",   ifc4.Retired_W,   r4);
    chk("ImmSrc_D_w4",  ifc4.ImmSrc_D,    d.imm);
`ifdef ILLEGAL_INSTR_EN
    chk("Illegal_W",    ifc.Illegal_W,    pipe[2].ill);
`endif
  endtask

  // One clock: drive, edge, model update, compare on the falling edge
  task automatic step(input logic [31:0] instr, input logic fl, input logic rs);
    ifc.Instr_D  = instr;
    ifc4.Instr_D = instr;
    ifc.Flush_E  = fl;
    ifc4.Flush_E = fl;
    rst_r        = rs;
    @(posedge clk);
    model_edge(instr, fl, rs);
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: w[6:0] = 7'h03;
      1: w[6:0] = 7'h23;
      2: w[6:0] = 7'h33;
      3: w[6:0] = 7'h13;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h6F;
      6: w = 32'd0;
      7: begin
        w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13;
        case ($urandom_range(0, 3))
          0: w[14:12] = 3'd0;
          1: w[14:12] = 3'd2;
          2: w[14:12] = 3'd6;
          default: w[14:12] = 3'd7;
        endcase
      end
      default: ;
    endcase
    return w;
  endfunction

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] ADDI = 32'h00A00093;
  localparam logic [31:0] LW   = 32'h00402283;
  localparam logic [31:0] SW   = 32'h00502423;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] JAL  = 32'h010000EF;

  initial begin
    exp_t z;
    z           = '0;
    total       = 0;
    bad         = 0;
    retired_cnt = 0;
    pipe        = {z, z, z};

    // Reset state
    step(32'd0, 1'b0, 1'b1);
    step(32'd0, 1'b0, 1'b1);
    chk("lit_rst_retired", ifc.Retired_W, 32'd0);
    chk("lit_rst_regwrite_w", ifc.RegWrite_W, 32'd0);

    // add flows through; counter steps one clock after it sits in W
    step(ADD, 1'b0, 1'b0);
    chk("lit_add_alu_e", ifc.ALUControl_E, 32'd0);
    chk("lit_add_srcb_e", ifc.ALUSrcB_E, 32'd0);
    step(32'd0, 1'b0, 1'b0);
    chk("lit_add_regwrite_m", ifc.RegWrite_M, 32'd1);
    step(32'd0, 1'b0, 1'b0);
    chk("lit_add_regwrite_w", ifc.RegWrite_W, 32'd1);
    chk("lit_add_resultsrc_w", ifc.ResultSrc_W, 32'd0);
    step(32'd0, 1'b0, 1'b0);
    chk("lit_add_retired", ifc.Retired_W, 32'd1);

    // sub vs addi
    step(SUB, 1'b0, 1'b0);
    chk("lit_sub_alu_e", ifc.ALUControl_E, 32'd1);
    step(ADDI, 1'b0, 1'b0);
    chk("lit_addi_alu_e", ifc.ALUControl_E, 32'd0);
    chk("lit_addi_srcb_e", ifc.ALUSrcB_E, 32'd1);

    // lw then sw
    step(LW, 1'b0, 1'b0);
    chk("lit_lw_imm_d", ifc.ImmSrc_D, 32'd0);
    chk("lit_lw_res_e0", ifc.ResultSrc_E0, 32'd1);
    step(SW, 1'b0, 1'b0);
    chk("lit_sw_imm_d", ifc.ImmSrc_D, 32'd1);
    chk("lit_lw_regwrite_m", ifc.RegWrite_M, 32'd1);
    step(32'd0, 1'b0, 1'b0);
    chk("lit_sw_memwrite_m", ifc.MemWrite_M, 32'd1);
    chk("lit_lw_resultsrc_w", ifc.ResultSrc_W, 32'd1);

    // beq followed by a flushed slot
    step(BEQ, 1'b0, 1'b0);
    chk("lit_beq_branch_e", ifc.Branch_E, 32'd1);
    chk("lit_beq_imm_d", ifc.ImmSrc_D, 32'd2);
    step(BEQ, 1'b1, 1'b0);
    chk("lit_flush_branch_e", ifc.Branch_E, 32'd0);
    chk("lit_flush_alu_e", ifc.ALUControl_E, 32'd0);
    step(32'd0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);

    // jal
    step(JAL, 1'b0, 1'b0);
    chk("lit_jal_imm_d", ifc.ImmSrc_D, 32'd3);
    chk("lit_jal_jump_e", ifc.Jump_E, 32'd1);
    step(32'd0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);
    chk("lit_jal_resultsrc_w", ifc.ResultSrc_W, 32'd2);
    chk("lit_jal_regwrite_w", ifc.RegWrite_W, 32'd1);

`ifdef ILLEGAL_INSTR_EN
    step(32'h0000007F, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);
    chk("lit_illegal_w", ifc.Illegal_W, 32'd1);
`endif

    // Counter wrap on the 4-bit instance: 15 retirements, then one more
    step(32'd0, 1'b0, 1'b1);
    for (int n = 0; n < 16; n++) step(ADD, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);
    chk("lit_wrap_pre4", ifc4.Retired_W, 32'd15);
    step(32'd0, 1'b0, 1'b0);
    chk("lit_wrap_post4", ifc4.Retired_W, 32'd0);
    chk("lit_wrap_post32", ifc.Retired_W, 32'd16);

    // Reset with three instructions in flight
    step(ADD, 1'b0, 1'b0);
    step(LW, 1'b0, 1'b0);
    step(JAL, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b1);
    chk("lit_midrst_regwrite_w", ifc.RegWrite_W, 32'd0);
    chk("lit_midrst_resultsrc_w", ifc.ResultSrc_W, 32'd0);
    chk("lit_midrst_retired", ifc.Retired_W, 32'd0);
    chk("lit_midrst_regwrite_m", ifc.RegWrite_M, 32'd0);

    // Random stream with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      step(rand_instr(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
